// File: rtl/bist_session_scheduler.sv
// Runs one BIST pass per enabled core through a shared controller and collects per-core verdicts.
// Optional watchdog per core run: define BIST_TIMEOUT_EN.
module bist_session_scheduler #(
  parameter int  NUM_CORES      = 4,
  parameter int  TIMEOUT_CYCLES = 700,
  localparam int SEL_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_mask,
  output logic                 ctl_start,
  output logic [SEL_W-1:0]     core_sel,
  input  logic                 ctl_done,
  input  logic                 ctl_pass,
  output logic                 busy,
  output logic                 done,
  output logic                 pass_fail,
  output logic [NUM_CORES-1:0] fail_vec,
  output logic                 timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  if (NUM_CORES < 2 || NUM_CORES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("bist_session_scheduler: parameter out of range");
  end

  logic [2:0]           state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] fail_vec_q, fail_vec_d;
  logic [SEL_W-1:0]     core_sel_q, core_sel_d, low_idx;
  logic                 ctl_start_q, ctl_start_d;
  logic                 busy_q, busy_d;
  logic                 sess_done_q, sess_done_d;
  logic                 pass_fail_q, pass_fail_d;
  logic                 done_q, done_edge;
  logic                 timeout_q, timeout_d;

`ifdef BIST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  // A level left high by the previous run must not count as completion.
  assign done_edge = ctl_done & ~done_q;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (mask_q[i]) low_idx = SEL_W'(i);
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    fail_vec_d  = fail_vec_q;
    core_sel_d  = core_sel_q;
    ctl_start_d = 1'b0;
    busy_d      = busy_q;
    sess_done_d = 1'b0;
    pass_fail_d = pass_fail_q;
    timeout_d   = timeout_q;
`ifdef BIST_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d     = core_mask;
          fail_vec_d = '0;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = (core_mask == '0) ? S_FINISH : S_SELECT;
        end
      end
      S_SELECT: begin
        if (mask_q != '0) begin
          core_sel_d      = low_idx;
          mask_d[low_idx] = 1'b0;
          ctl_start_d     = 1'b1;
          state_d         = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_LAUNCH: begin
`ifdef BIST_TIMEOUT_EN
        wdog_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_edge) begin
          fail_vec_d[core_sel_q] = ~ctl_pass;
          state_d                = S_SELECT;
`ifdef BIST_TIMEOUT_EN
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          fail_vec_d[core_sel_q] = 1'b1;
          timeout_d              = 1'b1;
          state_d                = S_SELECT;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
`endif
        end
      end
      S_FINISH: begin
        sess_done_d = 1'b1;
        pass_fail_d = (fail_vec_q == '0);
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      fail_vec_q  <= '0;
      core_sel_q  <= '0;
      ctl_start_q <= 1'b0;
      busy_q      <= 1'b0;
      sess_done_q <= 1'b0;
      pass_fail_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef BIST_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      fail_vec_q  <= fail_vec_d;
      core_sel_q  <= core_sel_d;
      ctl_start_q <= ctl_start_d;
      busy_q      <= busy_d;
      sess_done_q <= sess_done_d;
      pass_fail_q <= pass_fail_d;
      done_q      <= ctl_done;
      timeout_q   <= timeout_d;
`ifdef BIST_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign ctl_start = ctl_start_q;
  assign core_sel  = core_sel_q;
  assign busy      = busy_q;
  assign done      = sess_done_q;
  assign pass_fail = pass_fail_q;
  assign fail_vec  = fail_vec_q;
`ifdef BIST_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Bench for bist_session_scheduler: table sessions, random sessions against a session-level model,
// and hand sequences for reset, empty mask, back-to-back and watchdog behaviour.
module tb_bist_session_scheduler;
  localparam int NC = 4;
  localparam int TO = 700;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NC-1:0] core_mask = '0;
  logic          ctl_start;
  logic [1:0]    core_sel;
  logic          ctl_done;
  logic          ctl_pass;
  logic          busy, done, pass_fail, timeout;
  logic [NC-1:0] fail_vec;

  int applied = 0;
  int errors  = 0;
  int cyc     = 0;

  bist_session_scheduler #(.NUM_CORES(NC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .core_mask(core_mask),
    .ctl_start(ctl_start), .core_sel(core_sel), .ctl_done(ctl_done), .ctl_pass(ctl_pass),
    .busy(busy), .done(done), .pass_fail(pass_fail), .fail_vec(fail_vec), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: bist_end stays high after a run, drops 2 cycles into the next run,
  // rises rsp_delay cycles after ctl_start; pass_fail is garbage except on the rising cycle.
  int            rsp_delay = 4;
  logic [NC-1:0] rsp_pass = '0;
  logic [NC-1:0] rsp_hang = '0;
  int            rsp_cnt = 0;
  int            rsp_sel = 0;
  bit            rsp_act = 0;
  int            launch_sel[$];
  int            launch_cyc[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            sel_errs = 0;

  always @(negedge clk) begin
    if (reset) begin
      ctl_done = 1'b0;
      ctl_pass = 1'b0;
      rsp_act  = 0;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rsp_act && !ctl_start && int'(core_sel) != rsp_sel) sel_errs++;
      if (ctl_start) begin
        launch_sel.push_back(int'(core_sel));
        launch_cyc.push_back(cyc);
        rsp_act  = 1;
        rsp_cnt  = 0;
        rsp_sel  = int'(core_sel);
        ctl_pass = 1'($urandom);
      end else if (rsp_act) begin
        rsp_cnt++;
        if (rsp_cnt == 2) ctl_done = 1'b0;
        if (rsp_cnt == rsp_delay && !rsp_hang[rsp_sel]) begin
          ctl_done = 1'b1;
          ctl_pass = rsp_pass[rsp_sel];
          rsp_act  = 0;
        end else begin
          ctl_pass = 1'($urandom);
        end
      end else begin
        ctl_pass = 1'($urandom);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Session-level model: cores run in ascending order, each run takes d+2 cycles launch-to-launch
  // (TO+2 if it hangs), done arrives d+3 after the last launch, 2 after start for an empty mask.
  task automatic run_session(input logic [NC-1:0] m, input logic [NC-1:0] pbits,
                             input logic [NC-1:0] hang, input int d, input bit poke,
                             input logic [NC-1:0] exp_fail, input logic exp_pf);
    int ls0, dc0, se0, c0, t, n, gap;
    int exp_q[$];
    bit ord_ok, tim_ok, exp_to;
    rsp_pass = pbits; rsp_hang = hang; rsp_delay = d;
    ls0 = launch_sel.size(); dc0 = done_cnt; se0 = sel_errs;
    exp_to = 0;
    for (int i = 0; i < NC; i++)
      if (m[i]) begin
        exp_q.push_back(i);
        if (hang[i]) exp_to = 1;
      end
`ifndef BIST_TIMEOUT_EN
    exp_to = 0;
`endif
    @(negedge clk); core_mask = m; start = 1'b1; c0 = cyc;
    @(negedge clk); start = 1'b0; core_mask = NC'($urandom);
    if (poke && m != '0) begin
      repeat (2) @(negedge clk);
      start = 1'b1; core_mask = ~m;
      repeat (2) @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == dc0 && t < NC * (TO + 10) + 50) begin @(negedge clk); t++; end
    if (done_cnt == dc0) chk("done_wait", 32'(t), 32'(0));
    repeat (3) @(negedge clk);
    chk("fail_vec", 32'(fail_vec), 32'(exp_fail));
    chk("pass_fail", 32'(pass_fail), 32'(exp_pf));
    chk("timeout", 32'(timeout), 32'(exp_to));
    chk("busy_end", 32'(busy), 32'(0));
    chk("done_pulses", 32'(done_cnt - dc0), 32'(1));
    chk("sel_stable", 32'(sel_errs - se0), 32'(0));
    n = launch_sel.size() - ls0;
    ord_ok = (n == exp_q.size());
    for (int k = 0; k < n && ord_ok; k++)
      if (launch_sel[ls0 + k] != exp_q[k]) ord_ok = 0;
    chk("launch_order", 32'(ord_ok), 32'(1));
    if (ord_ok) begin
      if (n == 0) tim_ok = (done_cyc - c0 == 2);
      else begin
        tim_ok = (launch_cyc[ls0] - c0 == 2);
        for (int k = 0; k < n; k++) begin
          gap = hang[exp_q[k]] ? TO + 2 : d + 2;
          if (k < n - 1) begin
            if (launch_cyc[ls0 + k + 1] - launch_cyc[ls0 + k] != gap) tim_ok = 0;
          end else if (done_cyc - launch_cyc[ls0 + k] != gap + 1) tim_ok = 0;
        end
      end
      chk("timing", 32'(tim_ok), 32'(1));
    end
  endtask

  typedef struct {
    logic [NC-1:0] mask;
    logic [NC-1:0] pbits;
    int            d;
    logic [NC-1:0] exp_fail;
    logic          exp_pf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int dc0, ls0, t;
    logic [NC-1:0] m, p;
    tbl[0] = '{4'b1011, 4'b1111, 650, 4'b0000, 1'b1};
    tbl[1] = '{4'b0110, 4'b1011,  30, 4'b0100, 1'b0};
    tbl[2] = '{4'b1111, 4'b0000,  10, 4'b1111, 1'b0};
    tbl[3] = '{4'b0000, 4'b0000,   4, 4'b0000, 1'b1};
    tbl[4] = '{4'b1000, 4'b0111,   5, 4'b1000, 1'b0};
    tbl[5] = '{4'b0001, 4'b1111,   4, 4'b0000, 1'b1};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_outs", 32'({ctl_start, core_sel, busy, done, pass_fail, fail_vec, timeout}), 32'(0));
    chk("reset_no_launch", 32'(launch_sel.size()), 32'(0));

    for (int i = 0; i < 6; i++)
      run_session(tbl[i].mask, tbl[i].pbits, '0, tbl[i].d, 1'b0, tbl[i].exp_fail, tbl[i].exp_pf);

`ifdef BIST_TIMEOUT_EN
    run_session(4'b0111, 4'b1111, 4'b0010, 20, 1'b0, 4'b0010, 1'b0);
`endif

    for (int i = 0; i < 20; i++) begin
      m = NC'($urandom);
      p = NC'($urandom);
      run_session(m, p, '0, $urandom_range(4, 40), 1'($urandom), m & ~p, (m & ~p) == '0);
    end

    // start held high across FINISH: second session begins right away.
    dc0 = done_cnt; ls0 = launch_sel.size();
    rsp_pass = '1; rsp_hang = '0; rsp_delay = 6;
    @(negedge clk); core_mask = 4'b0011; start = 1'b1;
    t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    core_mask = 4'b0100;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("b2b_dones", 32'(done_cnt - dc0), 32'(2));
    chk("b2b_launches", 32'(launch_sel.size() - ls0), 32'(3));
    if (launch_sel.size() - ls0 == 3)
      chk("b2b_order", 32'({launch_sel[ls0][3:0], launch_sel[ls0+1][3:0], launch_sel[ls0+2][3:0]}),
          32'(12'h012));
    chk("b2b_pass", 32'({pass_fail, fail_vec}), 32'(5'b10000));

    // Reset in the middle of a run.
    rsp_pass = '0; rsp_delay = 650;
    @(negedge clk); core_mask = 4'b1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'(1));
    dc0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("mid_reset_outs", 32'({ctl_start, core_sel, busy, done, pass_fail, fail_vec, timeout}), 32'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ls0 = launch_sel.size();
    repeat (10) @(negedge clk);
    chk("mid_reset_no_done", 32'(done_cnt - dc0), 32'(0));
    chk("mid_reset_no_launch", 32'(launch_sel.size() - ls0), 32'(0));
    chk("mid_reset_idle", 32'({busy, pass_fail, fail_vec}), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule

// File: doc/bist_session_scheduler.md
Name: bist_session_scheduler

Overview:
Sequences a BIST session across up to NUM_CORES circuit-under-test instances. The instances share one BIST controller start/end/pass-fail handshake through a core-select mux. On a session request, the block launches the controller once per enabled core, in ascending index order, and records each core's pass/fail result. It then reports an aggregate verdict plus a per-core failure vector. It sits above the per-core BIST controllers and below the top-level test access logic.

Parameters:
NUM_CORES, 4, number of cores under test (2..16)
TIMEOUT_CYCLES, 700, watchdog limit in clk cycles per core run (used only with BIST_TIMEOUT_EN)
SEL_W, derived localparam = max(1, $clog2(NUM_CORES)), width of core_sel

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  session request, level, sampled only in IDLE
core_mask  input  NUM_CORES  cores to test this session, sampled with start
ctl_start  output  1  start pulse to shared BIST controller
core_sel  output  SEL_W  index of core currently routed to controller
ctl_done  input  1  controller bist_end (level, may be stale-high from previous run)
ctl_pass  input  1  controller pass_fail, valid when ctl_done rises
busy  output  1  session in progress
done  output  1  one-cycle pulse at session end
pass_fail  output  1  aggregate verdict, 1 = all tested cores passed
fail_vec  output  NUM_CORES  bit i = 1 if core i failed (or timed out)
timeout  output  1  sticky: some core timed out this session (0 when feature off)

Behaviour:
- Reset (async, immediate): state IDLE; ctl_start, core_sel, busy, done, pass_fail, fail_vec, timeout and internal mask/counter/done_q registers all 0. Reset mid-session aborts with no done pulse; ctl_start drops in the same instant.
- Rising-edge detect on ctl_done: done_q registers ctl_done every cycle; done_edge = ctl_done & !done_q. A level-high ctl_done left over from a prior run is never taken as completion.
- States: IDLE, SELECT, LAUNCH, WAIT, FINISH.
- IDLE, start=1:
  - Latch core_mask into mask_q, clear fail_vec and timeout, busy<=1.
  - If core_mask==0, go to FINISH; the result is a vacuous pass.
  - Otherwise go to SELECT.
- IDLE, start=0: stay in IDLE. pass_fail and fail_vec hold their last session values.
- SELECT (1 cycle):
  - If mask_q!=0, core_sel <= index of lowest set bit, clear that bit in mask_q, go to LAUNCH.
  - If mask_q==0, go to FINISH.
- LAUNCH (1 cycle): ctl_start=1 (registered output, exactly one cycle high); clear watchdog counter; go to WAIT.
- WAIT:
  - core_sel is held stable.
  - On done_edge: fail_vec[core_sel] <= !ctl_pass, go to SELECT.
  - Otherwise increment the watchdog (feature on only) and stay.
- FINISH (1 cycle): done=1, pass_fail <= (fail_vec==0), busy<=0, go to IDLE.
- Latency per core: 1 (SELECT) + 1 (LAUNCH) + controller run + 1-cycle edge detect. Session end: done asserts 1 cycle after the last completion is recorded.
- start while busy: ignored, with no restart and no effect on mask_q.
- start held high across FINISH: a new session begins on the first IDLE cycle, i.e. back-to-back sessions.
- ctl_done edge outside WAIT: ignored.
- ctl_pass is sampled only in the done_edge cycle.

Optional Feature:
BIST_TIMEOUT_EN
- Defined:
  - A watchdog counter of width $clog2(TIMEOUT_CYCLES+1) counts WAIT cycles.
  - When it reaches TIMEOUT_CYCLES without done_edge: fail_vec[core_sel]<=1, timeout<=1 (sticky until next session start), go to SELECT.
  - A done_edge in the same cycle as expiry takes priority; the core is recorded normally.
- Undefined: no counter is present; WAIT waits indefinitely and timeout is tied to 0.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0; ctl_start never pulses.
- core_mask=4'b1011, all runs pass with ctl_done rising 650 cycles after each ctl_start -> ctl_start pulses with core_sel 0,1,3 in order; done pulses once; pass_fail=1; fail_vec=0000.
- core_mask=4'b0110, core 2 returns ctl_pass=0 -> fail_vec=0100, pass_fail=0.
- ctl_done held high from the previous run at launch, drops 2 cycles later, rises at cycle 650 -> completion recorded only at the rise, not at launch.
- core_mask=0 -> done pulses 2 cycles after start, pass_fail=1, no ctl_start.
- BIST_TIMEOUT_EN, TIMEOUT_CYCLES=700, core 1 never completes -> after 700 WAIT cycles fail_vec[1]=1, timeout=1, and the session proceeds to the next core.
- Reset asserted mid-WAIT -> all outputs 0 immediately, no done pulse.
